// File: rtl/br_predict_resolve.sv
// br_predict_resolve: EX-stage branch resolve/redirect unit with a 2-bit saturating BHT for IF prediction.
//   Optional perf counters are compiled in when BR_PERF_CNT_EN is defined.
//   Ports:
//     i_clk, i_rst_n                     clock, synchronous active-low reset
//     i_if_pc -> o_if_pred_taken         IF-side BHT lookup (combinational)
//     i_ex_*, i_ctrl_LT/LTU/EQ           EX branch info and comparator flags
//     o_ex_taken, o_redirect(_pc)        resolved direction and mispredict redirect
//     o_br_cnt, o_mispred_cnt            resolved-branch and mispredict counters (BR_PERF_CNT_EN only)
module br_predict_resolve #(
    parameter int DATA_WIDTH = 32,
    parameter int BHT_IDX_W  = 6
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic [DATA_WIDTH-1:0] i_if_pc,
    output logic                  o_if_pred_taken,
    input  logic                  i_ex_valid,
    input  logic                  i_ex_is_branch,
    input  logic                  i_ex_stall,
    input  logic [2:0]            i_ex_funct3,
    input  logic [DATA_WIDTH-1:0] i_ex_pc,
    input  logic [DATA_WIDTH-1:0] i_ex_target,
    input  logic                  i_ex_pred_taken,
    input  logic                  i_ctrl_LT,
    input  logic                  i_ctrl_LTU,
    input  logic                  i_ctrl_EQ,
    output logic                  o_ex_taken,
    output logic                  o_redirect,
`ifdef BR_PERF_CNT_EN
    output logic [DATA_WIDTH-1:0] o_redirect_pc,
    output logic [31:0]           o_br_cnt,
    output logic [31:0]           o_mispred_cnt
`else
    output logic [DATA_WIDTH-1:0] o_redirect_pc
`endif
);
    logic [1:0]           r_bht [2**BHT_IDX_W];
    logic [BHT_IDX_W-1:0] w_if_idx;
    logic [BHT_IDX_W-1:0] w_ex_idx;
    logic                 w_legal;
    logic                 w_dir;
    logic                 w_ex_br;
    logic                 w_upd;
    logic                 w_unused_if_pc;

    assign w_if_idx       = i_if_pc[BHT_IDX_W+1:2];
    assign w_ex_idx       = i_ex_pc[BHT_IDX_W+1:2];
    assign w_unused_if_pc = ^i_if_pc;
    assign w_legal        = i_ex_funct3[2:1] != 2'b01;
    // funct3[2:1] picks the flag, funct3[0] inverts it (BNE/BGE/BGEU)
    assign w_dir   = (i_ex_funct3[2:1] == 2'b00 ? i_ctrl_EQ :
                      i_ex_funct3[2:1] == 2'b10 ? i_ctrl_LT : i_ctrl_LTU) ^ i_ex_funct3[0];
    assign w_ex_br = i_ex_valid & i_ex_is_branch & w_legal;
    assign w_upd   = w_ex_br & ~i_ex_stall;

    assign o_if_pred_taken = i_rst_n & r_bht[w_if_idx][1];
    assign o_ex_taken      = i_rst_n & w_ex_br & w_dir;
    assign o_redirect      = i_rst_n & w_upd & (w_dir != i_ex_pred_taken);
    assign o_redirect_pc   = !o_redirect ? '0 :
                             o_ex_taken ? i_ex_target : i_ex_pc + DATA_WIDTH'(4);

    // IF reads the registered array directly, so a same-cycle write is not bypassed
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            for (int i = 0; i < 2**BHT_IDX_W; i++) r_bht[i] <= 2'b01;
        end else if (w_upd) begin
            if (w_dir) r_bht[w_ex_idx] <= r_bht[w_ex_idx] == 2'b11 ? 2'b11 : r_bht[w_ex_idx] + 2'd1;
            else       r_bht[w_ex_idx] <= r_bht[w_ex_idx] == 2'b00 ? 2'b00 : r_bht[w_ex_idx] - 2'd1;
        end
    end

`ifdef BR_PERF_CNT_EN
    logic [31:0] r_br_cnt;
    logic [31:0] r_mispred_cnt;
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_br_cnt      <= '0;
            r_mispred_cnt <= '0;
        end else begin
            r_br_cnt      <= r_br_cnt + 32'(w_upd);
            r_mispred_cnt <= r_mispred_cnt + 32'(o_redirect);
        end
    end
    assign o_br_cnt      = r_br_cnt;
    assign o_mispred_cnt = r_mispred_cnt;
`endif
endmodule

// File: tb/tb_br_predict_resolve.sv
// tb_br_predict_resolve: directed plus random checking of br_predict_resolve against a behavioural model.
module tb_br_predict_resolve;
    logic        clk = 0;
    logic        rst_n = 0;
    logic [31:0] if_pc = 0;
    logic        pred_o;
    logic        valid = 0, isb = 0, stall = 0, pred = 0, lt = 0, ltu = 0, eq = 0;
    logic [2:0]  f3 = 0;
    logic [31:0] ex_pc = 0, tgt = 0;
    logic        taken_o, red_o;
    logic [31:0] rpc_o;
`ifdef BR_PERF_CNT_EN
    logic [31:0] br_cnt_o, mis_cnt_o;
`endif

    int     n_tests = 0, n_fail = 0;
    int     bht [64];
    longint m_br = 0, m_mis = 0;
    bit     inited = 0;

    always #5 clk = ~clk;

    br_predict_resolve dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_if_pc(if_pc), .o_if_pred_taken(pred_o),
        .i_ex_valid(valid), .i_ex_is_branch(isb), .i_ex_stall(stall), .i_ex_funct3(f3),
        .i_ex_pc(ex_pc), .i_ex_target(tgt), .i_ex_pred_taken(pred),
        .i_ctrl_LT(lt), .i_ctrl_LTU(ltu), .i_ctrl_EQ(eq),
        .o_ex_taken(taken_o), .o_redirect(red_o),
`ifdef BR_PERF_CNT_EN
        .o_redirect_pc(rpc_o), .o_br_cnt(br_cnt_o), .o_mispred_cnt(mis_cnt_o)
`else
        .o_redirect_pc(rpc_o)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Spec-level direction rule per mnemonic
    function automatic bit resolve(input logic [2:0] f, input bit l, input bit lu, input bit e);
        case (f)
            3'd0: return e;
            3'd1: return !e;
            3'd4: return l;
            3'd5: return !l;
            3'd6: return lu;
            3'd7: return !lu;
            default: return 0;
        endcase
    endfunction

    // Check outputs mid-cycle, then advance the model on the edge
    task automatic tick();
        bit legal, exbr, d, e_t, e_r, e_p;
        logic [31:0] e_rpc;
        int ei;
        legal = (f3 != 3'd2) && (f3 != 3'd3);
        exbr  = valid && isb && legal;
        d     = resolve(f3, lt, ltu, eq);
        e_t   = rst_n && exbr && d;
        e_r   = rst_n && exbr && (d != pred) && !stall;
        e_rpc = !e_r ? 32'h0 : (e_t ? tgt : ex_pc + 32'd4);
        e_p   = rst_n && inited && bht[(if_pc / 4) % 64] >= 2;
        ei    = (ex_pc / 4) % 64;
        #1;
        chk("if_pred", {31'b0, pred_o}, {31'b0, e_p});
        chk("ex_taken", {31'b0, taken_o}, {31'b0, e_t});
        chk("redirect", {31'b0, red_o}, {31'b0, e_r});
        chk("redirect_pc", rpc_o, e_rpc);
`ifdef BR_PERF_CNT_EN
        if (inited) begin
            chk("br_cnt", br_cnt_o, 32'(m_br));
            chk("mispred_cnt", mis_cnt_o, 32'(m_mis));
        end
`endif
        @(posedge clk);
        if (!rst_n) begin
            foreach (bht[i]) bht[i] = 1;
            m_br = 0; m_mis = 0; inited = 1;
        end else if (exbr && !stall) begin
            bht[ei] = d ? (bht[ei] < 3 ? bht[ei] + 1 : 3) : (bht[ei] > 0 ? bht[ei] - 1 : 0);
            m_br++;
            if (e_r) m_mis++;
        end
        @(negedge clk);
    endtask

    task automatic br(input logic [2:0] f, input logic [31:0] pc, input logic [31:0] t,
                      input bit p, input bit l, input bit lu, input bit e, input bit s);
        valid = 1; isb = 1; f3 = f; ex_pc = pc; tgt = t; pred = p; lt = l; ltu = lu; eq = e; stall = s;
        tick();
    endtask

    task automatic idle();
        valid = 0; isb = 0; stall = 0;
        tick();
    endtask

    initial begin
        @(negedge clk);
        rst_n = 0; if_pc = 32'h100;
        br(3'd0, 32'h100, 32'h200, 0, 0, 0, 1, 0);
        br(3'd0, 32'h100, 32'h200, 0, 0, 0, 1, 0);
        rst_n = 1;
        idle();
        br(3'd0, 32'h100, 32'h200, 0, 0, 0, 1, 0);
        idle();
        br(3'd7, 32'h300, 32'h380, 1, 0, 0, 0, 0);
        br(3'd4, 32'hFFFFFFFC, 32'h10, 1, 0, 0, 0, 0);
        if_pc = 32'h20;
        for (int k = 0; k < 4; k++) br(3'd1, 32'h20, 32'h0, k > 1, 0, 0, 0, 0);
        br(3'd1, 32'h20, 32'h0, 1, 0, 0, 1, 0);
        idle();
        if_pc = 32'h60;
        for (int k = 0; k < 3; k++) br(3'd6, 32'h60, 32'h70, 0, 0, 1, 0, 1);
        br(3'd6, 32'h60, 32'h70, 0, 0, 1, 0, 0);
        br(3'd6, 32'h60, 32'h70, 1, 0, 0, 0, 0);
        idle();
        if_pc = 32'h80;
        br(3'd2, 32'h80, 32'h90, 0, 1, 1, 1, 0);
        br(3'd3, 32'h80, 32'h90, 1, 1, 1, 1, 0);
        idle();
        if_pc = 32'h40;
        br(3'd5, 32'h40, 32'h50, 0, 0, 0, 0, 0);
        br(3'd5, 32'h40, 32'h50, 1, 0, 0, 0, 0);
        idle();
        rst_n = 0;
        br(3'd0, 32'h40, 32'h50, 0, 0, 0, 1, 0);
        rst_n = 1;
        if_pc = 32'h100;
        idle();
        if_pc = 32'h40;
        idle();
        for (int k = 0; k < 400; k++) begin
            rst_n = ($urandom_range(0, 99) != 0);
            if_pc = ($urandom_range(0, 1) != 0) ? {$urandom_range(0, 15), 2'b0} : $urandom;
            valid = $urandom_range(0, 7) != 0;
            isb   = $urandom_range(0, 5) != 0;
            stall = $urandom_range(0, 3) == 0;
            f3    = 3'($urandom);
            ex_pc = ($urandom_range(0, 1) != 0) ? {$urandom_range(0, 15), 2'b0} : $urandom;
            tgt   = $urandom;
            pred  = 1'($urandom);
            lt    = 1'($urandom);
            ltu   = 1'($urandom);
            eq    = 1'($urandom);
            tick();
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/br_predict_resolve.md
# br_predict_resolve

Branch predict-and-resolve unit for the 5-stage RV32 pipeline. It sits directly downstream of the branch comparator in EX. It consumes the comparator's LT/LTU/EQ flags, resolves the actual branch direction from funct3, and raises a redirect/flush on mispredict. It also owns a 2-bit saturating branch history table (BHT) that IF reads for its taken/not-taken prediction, and EX updates once each branch resolves.

## Interface
Parameters:
- DATA_WIDTH, 32, PC/target width
- BHT_IDX_W, 6, log2 of BHT entries (64 entries); index = PC[BHT_IDX_W+1:2]

Ports:
- i_clk  in  1  pipeline clock, all state updates on rising edge
- i_rst_n  in  1  reset, synchronous, active-low
- i_if_pc  in  DATA_WIDTH  PC being fetched
- o_if_pred_taken  out  1  prediction for i_if_pc (combinational)
- i_ex_valid  in  1  EX holds a live instruction
- i_ex_is_branch  in  1  EX instruction is a conditional branch (opcode 1100011)
- i_ex_stall  in  1  EX frozen this cycle; no BHT/counter update
- i_ex_funct3  in  3  branch funct3
- i_ex_pc  in  DATA_WIDTH  PC of EX branch
- i_ex_target  in  DATA_WIDTH  computed branch target
- i_ex_pred_taken  in  1  prediction carried down the pipe from IF
- i_ctrl_LT / i_ctrl_LTU / i_ctrl_EQ  in  1 each  branch comparator flags
- o_ex_taken  out  1  resolved direction
- o_redirect  out  1  mispredict; flush IF/ID and load o_redirect_pc
- o_redirect_pc  out  DATA_WIDTH  corrected fetch PC
- o_br_cnt, o_mispred_cnt  out  32 each  performance counters (only with BR_PERF_CNT_EN)

## Operation
- Resolve (ex_br = i_ex_valid & i_ex_is_branch & legal funct3):
  - 000 BEQ = EQ
  - 001 BNE = !EQ
  - 100 BLT = LT
  - 101 BGE = !LT
  - 110 BLTU = LTU
  - 111 BGEU = !LTU
- funct3 010/011 is illegal: o_ex_taken=0, no redirect, no update.
- o_ex_taken = resolved direction when ex_br, else 0.
- o_redirect = ex_br & (o_ex_taken != i_ex_pred_taken) & !i_ex_stall.
- o_redirect_pc:
  - o_ex_taken ? i_ex_target : i_ex_pc+4, truncated to DATA_WIDTH (0xFFFFFFFC+4 wraps to 0).
  - 0 when o_redirect=0.
- BHT: 2^BHT_IDX_W entries × 2-bit counter.
  - Prediction = counter[1].
  - Update on ex_br & !i_ex_stall: taken → increment, saturate at 11; not taken → decrement, saturate at 00.
- Simultaneous IF read and EX write to the same index: IF sees the pre-update value (no bypass).
- Aliasing between PCs that share an index is accepted; no tags.
- Perf counters (when enabled):
  - o_br_cnt increments on each ex_br & !i_ex_stall.
  - o_mispred_cnt increments on each o_redirect.
  - Both wrap modulo 2^32.

## Timing
- Prediction, resolve and redirect are combinational in the same cycle as their inputs: zero-cycle latency.
- BHT and counter updates take effect at the rising edge ending the EX cycle. IF reads of that index see the new value from the next cycle.
- A branch stalled for N cycles updates exactly once: in the cycle it leaves with i_ex_stall=0.
- Reset (i_rst_n=0 sampled at an edge):
  - All BHT entries are set to 01 (weakly not-taken) and the perf counters to 0.
  - While i_rst_n=0, o_if_pred_taken, o_ex_taken, o_redirect and o_redirect_pc are forced to 0.
- Reset mid-operation discards any in-flight update in that cycle; reset wins over update.

## Configuration
- BR_PERF_CNT_EN defined: o_br_cnt/o_mispred_cnt ports and their counters are present.
- BR_PERF_CNT_EN undefined: the ports and registers are absent; all other behaviour is identical.

## Test plan
- Reset, then i_if_pc=0x100 → o_if_pred_taken=0; all outputs 0 during reset; counters 0.
- BEQ at pc 0x100, EQ=1, pred=0, target 0x200 → o_ex_taken=1, o_redirect=1, o_redirect_pc=0x200; next cycle entry[0x100] =10, prediction 1; o_mispred_cnt=1.
- BGEU, LTU=0, pred=1 → taken, no redirect. BLT at pc 0xFFFFFFFC, LT=0, pred=1 → o_redirect_pc=0x0.
- Four consecutive taken updates on one index → counter saturates at 11. Then one not-taken → 10; prediction still 1.
- Branch held with i_ex_stall=1 for 3 cycles, then released → exactly one BHT update and o_br_cnt +1. funct3=010 → no redirect, no update.
- IF read and EX update of pc 0x40 in the same cycle → IF sees the old value. Assert i_rst_n=0 mid-sequence → table back to 01 and counters 0 on the next edge.
